// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin arbiter that funnels N memory clients onto one
// SRAM-like bus port. It handles one transaction at a time. Byte strobes are
// translated into a bus size and a low address.
module sram_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [4*NUM_MASTERS-1:0]          m_wstrb,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_addr,
    input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              s_req,
    output logic                              s_wr,
    output logic [1:0]                        s_size,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_addr_ok,
    input  logic                              s_data_ok,
    input  logic [DATA_WIDTH-1:0]             s_rdata
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    // Strobe pattern to {legal, size[1:0], low address[1:0]}; reads keep the address as given
    function automatic logic [4:0] decode_strobe(input logic [3:0] strb, input logic [1:0] lo_in);
        case (strb)
            4'b0000: return {1'b1, 2'b10, lo_in};
            4'b0001: return 5'b1_00_00;
            4'b0010: return 5'b1_00_01;
            4'b0100: return 5'b1_00_10;
            4'b1000: return 5'b1_00_11;
            4'b0011: return 5'b1_01_00;
            4'b1100: return 5'b1_01_10;
            4'b1111: return 5'b1_10_00;
            default: return 5'b0_00_00;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]        gidx_q, gidx_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic                    s_req_q, s_req_d;
    logic [3:0]              strb_q, strb_d;
    logic [ADDR_WIDTH-3:0]   addr_hi_q, addr_hi_d;
    logic [1:0]              lo_q, lo_d;
    logic [1:0]              size_q, size_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_MASTERS-1:0]  m_done_q, m_done_d;
    logic [NUM_MASTERS-1:0]  m_err_q, m_err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [NUM_MASTERS-1:0]  eff_req;
    logic                    found;
    logic [PTR_W-1:0]        cand;
    logic [PTR_W-1:0]        pick_ptr;
    logic [3:0]              pick_strb;
    logic [1:0]              pick_lo;
    logic [4:0]              pick_dec;
    logic [PTR_W-1:0]        next_ptr;

    // A master whose done pulse is showing is masked so it is not re-granted before it drops m_req
    assign eff_req = m_req & ~m_done_q;

    // Cyclic search for the first eligible requester at or after the round-robin pointer
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        pick_ptr = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = PTR_W'((int'(rr_q) + i) % NUM_MASTERS);
            if (!found && eff_req[cand]) begin
                found    = 1'b1;
                pick_ptr = cand;
            end
        end
        pick_strb = m_wstrb[int'(pick_ptr)*4 +: 4];
        pick_lo   = m_addr[int'(pick_ptr)*ADDR_WIDTH +: 2];
        pick_dec  = decode_strobe(pick_strb, pick_lo);
        next_ptr  = (gidx_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
    end

    // Next-state and next-output logic for the IDLE/ADDR/DATA/ERR transaction sequencer
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        s_req_d   = s_req_q;
        strb_d    = strb_q;
        addr_hi_d = addr_hi_q;
        lo_d      = lo_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        m_done_d  = '0;
        m_err_d   = '0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d            = pick_ptr;
                    grant_d           = '0;
                    grant_d[pick_ptr] = 1'b1;
                    strb_d            = pick_strb;
                    addr_hi_d         = m_addr[int'(pick_ptr)*ADDR_WIDTH + 2 +: ADDR_WIDTH-2];
                    wdata_d           = m_wdata[int'(pick_ptr)*DATA_WIDTH +: DATA_WIDTH];
                    size_d            = pick_dec[3:2];
                    lo_d              = pick_dec[1:0];
                    if (pick_dec[4]) begin
                        state_d = ADDR;
                        s_req_d = 1'b1;
                    end else begin
                        state_d            = ERR;
                        m_done_d[pick_ptr] = 1'b1;
                        m_err_d[pick_ptr]  = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (s_addr_ok) begin
                    s_req_d = 1'b0;
                    if (s_data_ok) begin
                        m_done_d = grant_q;
                        rdata_d  = (|strb_q) ? wdata_q : s_rdata;
                        grant_d  = '0;
                        rr_d     = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    m_done_d = grant_q;
                    rdata_d  = (|strb_q) ? wdata_q : s_rdata;
                    grant_d  = '0;
                    rr_d     = next_ptr;
                    state_d  = IDLE;
                end
            end
            ERR: begin
                grant_d = '0;
                rr_d    = next_ptr;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                s_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction and returns to IDLE at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            s_req_q   <= 1'b0;
            strb_q    <= '0;
            addr_hi_q <= '0;
            lo_q      <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            m_done_q  <= '0;
            m_err_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            s_req_q   <= s_req_d;
            strb_q    <= strb_d;
            addr_hi_q <= addr_hi_d;
            lo_q      <= lo_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            m_done_q  <= m_done_d;
            m_err_q   <= m_err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign grant   = grant_q;
    assign m_done  = m_done_q;
    assign m_err   = m_err_q;
    assign m_rdata = rdata_q;
    assign s_req   = s_req_q;
    assign s_wr    = |strb_q;
    assign s_size  = size_q;
    assign s_addr  = {addr_hi_q, lo_q};
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with two masters. Inputs change on the falling
// edge, and outputs are checked on the falling edge after the rising edge that
// produced them.
module tb_sram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mReq;
    logic [3:0]  wstrb0, wstrb1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  mDone, mErr, grant;
    logic [31:0] mRdata;
    logic        sReq, sWr;
    logic [1:0]  sSize;
    logic [31:0] sAddr, sWdata, sRdata;
    logic        sAddrOk, sDataOk;

    int checks   = 0;
    int failures = 0;
    logic [1:0] expGrant;

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    sram_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (mReq),
        .m_wstrb   ({wstrb1, wstrb0}),
        .m_addr    ({addr1, addr0}),
        .m_wdata   ({wdata1, wdata0}),
        .m_done    (mDone),
        .m_err     (mErr),
        .m_rdata   (mRdata),
        .grant     (grant),
        .s_req     (sReq),
        .s_wr      (sWr),
        .s_size    (sSize),
        .s_addr    (sAddr),
        .s_wdata   (sWdata),
        .s_addr_ok (sAddrOk),
        .s_data_ok (sDataOk),
        .s_rdata   (sRdata)
    );

    // Advance to the next falling edge, letting one rising edge consume the current inputs
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering read, write, fairness, illegal strobe, stall and reset
    initial begin
        rst = 1'b0; mReq = 2'b00;
        wstrb0 = 4'h0; wstrb1 = 4'h0; addr0 = 32'h0; addr1 = 32'h0;
        wdata0 = 32'h0; wdata1 = 32'h0;
        sAddrOk = 1'b0; sDataOk = 1'b0; sRdata = 32'h0;

        applyStimulus();
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_sreq", sReq, 1'b0);
        checkOutput("rst_done", mDone, 2'b00);
        checkOutput("rst_err", mErr, 2'b00);
        checkOutput("rst_rdata", mRdata, 32'h0);
        rst = 1'b1;

        $display("[TB] read from master 0");
        addr0 = 32'h0000_1000; wstrb0 = 4'b0000; mReq = 2'b01;
        applyStimulus();
        checkOutput("rd_grant", grant, 2'b01);
        checkOutput("rd_sreq", sReq, 1'b1);
        checkOutput("rd_swr", sWr, 1'b0);
        checkOutput("rd_size", sSize, 2'b10);
        checkOutput("rd_addr", sAddr, 32'h0000_1000);
        sAddrOk = 1'b1;
        applyStimulus();
        checkOutput("rd_sreq_drop", sReq, 1'b0);
        checkOutput("rd_grant_hold", grant, 2'b01);
        checkOutput("rd_no_early_done", mDone, 2'b00);
        sAddrOk = 1'b0; sDataOk = 1'b1; sRdata = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("rd_done", mDone, 2'b01);
        checkOutput("rd_data", mRdata, 32'hDEAD_BEEF);
        checkOutput("rd_grant_clr", grant, 2'b00);
        checkOutput("rd_err", mErr, 2'b00);
        sDataOk = 1'b0; sRdata = 32'h0; mReq = 2'b00;
        applyStimulus();
        checkOutput("rd_done_pulse", mDone, 2'b00);

        $display("[TB] byte write from master 1, addr_ok and data_ok together");
        wstrb1 = 4'b0100; addr1 = 32'h0000_2003; wdata1 = 32'h00AB_0000; mReq = 2'b10;
        applyStimulus();
        checkOutput("wr_grant", grant, 2'b10);
        checkOutput("wr_sreq", sReq, 1'b1);
        checkOutput("wr_addr", sAddr, 32'h0000_2002);
        checkOutput("wr_size", sSize, 2'b00);
        checkOutput("wr_swr", sWr, 1'b1);
        checkOutput("wr_wdata", sWdata, 32'h00AB_0000);
        sAddrOk = 1'b1; sDataOk = 1'b1;
        applyStimulus();
        checkOutput("wr_done", mDone, 2'b10);
        checkOutput("wr_echo", mRdata, 32'h00AB_0000);
        checkOutput("wr_sreq_drop", sReq, 1'b0);
        sAddrOk = 1'b0; sDataOk = 1'b0; mReq = 2'b00;
        applyStimulus();
        checkOutput("wr_done_pulse", mDone, 2'b00);

        $display("[TB] both masters requesting continuously");
        wstrb0 = 4'b0000; addr0 = 32'h0000_1000; mReq = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus();
            checkOutput("rr_grant", grant, expGrant);
            sAddrOk = 1'b1;
            applyStimulus();
            sAddrOk = 1'b0; sDataOk = 1'b1;
            applyStimulus();
            checkOutput("rr_done", mDone, expGrant);
            sDataOk = 1'b0;
            if (k == 3) mReq = 2'b00;
        end
        applyStimulus();

        $display("[TB] illegal strobe from master 0");
        wstrb0 = 4'b0110; mReq = 2'b01;
        applyStimulus();
        checkOutput("err_err", mErr, 2'b01);
        checkOutput("err_done", mDone, 2'b01);
        checkOutput("err_sreq", sReq, 1'b0);
        checkOutput("err_grant", grant, 2'b01);
        mReq = 2'b00;
        applyStimulus();
        checkOutput("err_done_pulse", mDone, 2'b00);
        checkOutput("err_err_pulse", mErr, 2'b00);
        checkOutput("err_sreq_after", sReq, 1'b0);
        checkOutput("err_grant_clr", grant, 2'b00);

        $display("[TB] slave stalls addr_ok, master inputs change after grant");
        wstrb0 = 4'b0011; addr0 = 32'h0000_3001; wdata0 = 32'h1234_5678; mReq = 2'b01;
        applyStimulus();
        checkOutput("stall_grant", grant, 2'b01);
        checkOutput("stall_swr", sWr, 1'b1);
        wstrb0 = 4'b1111; addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0;
        for (int k = 0; k < 5; k++) begin
            sDataOk = (k == 2);
            applyStimulus();
            checkOutput("stall_sreq", sReq, 1'b1);
            checkOutput("stall_addr", sAddr, 32'h0000_3000);
            checkOutput("stall_size", sSize, 2'b01);
            checkOutput("stall_no_done", mDone, 2'b00);
        end
        sDataOk = 1'b0; sAddrOk = 1'b1;
        applyStimulus();
        checkOutput("stall_sreq_drop", sReq, 1'b0);
        sAddrOk = 1'b0;
        applyStimulus();
        checkOutput("stall_data_wait", mDone, 2'b00);
        checkOutput("stall_grant_hold", grant, 2'b01);
        sDataOk = 1'b1;
        applyStimulus();
        checkOutput("stall_done", mDone, 2'b01);
        checkOutput("stall_wdata_latched", mRdata, 32'h1234_5678);
        sDataOk = 1'b0; mReq = 2'b00;
        applyStimulus();

        $display("[TB] asynchronous reset during data phase");
        wstrb1 = 4'b0000; addr1 = 32'h0000_4000; mReq = 2'b10;
        applyStimulus();
        checkOutput("ar_grant", grant, 2'b10);
        checkOutput("ar_sreq", sReq, 1'b1);
        sAddrOk = 1'b1;
        applyStimulus();
        sAddrOk = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_grant_async", grant, 2'b00);
        checkOutput("ar_sreq_async", sReq, 1'b0);
        checkOutput("ar_done_async", mDone, 2'b00);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("ar_regrant", grant, 2'b10);
        checkOutput("ar_resreq", sReq, 1'b1);
        checkOutput("ar_addr", sAddr, 32'h0000_4000);
        sAddrOk = 1'b1; sDataOk = 1'b1; sRdata = 32'hCAFE_F00D;
        applyStimulus();
        checkOutput("ar_done", mDone, 2'b10);
        checkOutput("ar_rdata", mRdata, 32'hCAFE_F00D);
        checkOutput("ar_grant_clr", grant, 2'b00);
        sAddrOk = 1'b0; sDataOk = 1'b0; mReq = 2'b00;
        applyStimulus();
        checkOutput("ar_done_pulse", mDone, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
